seg_display_sequencer: RTL and testbench
========================================

// Module: seg_display_sequencer
// PURPOSE
//   Downstream of the calculator core: takes its 8-bit accumulator result and shows it on the single
//   7-segment display. Serially converts binary to 3 BCD digits (shift-add-3, 1 bit/cycle), then steps
//   hundreds/tens/ones one at a time with blank gaps between them. Leading zeros are suppressed.
// PARAMETERS
//   DWELL  default 10_000_000  cycles each digit is lit (>=1)
//   GAP    default 2_000_000   cycles blank between digits (>=1); end-of-frame blank is 2*GAP
//   CNT_W  default 24          dwell/gap counter width; must hold max(DWELL, 2*GAP)
// PORTS
//   clk        in   1  single clock, all logic on posedge
//   reset      in   1  synchronous, active-high
//   value      in   8  unsigned binary result from calculator core
//   load       in   1  1-cycle strobe: capture value and (re)start display
//   seg        out  7  segments {g,f,e,d,c,b,a}, active-high, bit0 = a
//   dp         out  1  decimal point, lit only while ones digit shown (end-of-number marker)
//   digit_idx  out  2  digit shown: 2=hundreds 1=tens 0=ones 3=blank
//   busy       out  1  high while BCD conversion in progress
// BEHAVIOUR
//   Reset: all outputs registered; after reset seg=0, dp=0, digit_idx=3, busy=0, BCD regs=0,
//     pending=0, state IDLE. Reset wins over load in the same cycle, in any state.
//   States: IDLE, CONVERT, SHOW, GAP, FRAME_GAP.
//   IDLE: display blank; stays until load.
//   load in IDLE/SHOW/GAP/FRAME_GAP: value captured at that edge; next cycle state=CONVERT, busy=1,
//     seg=0, dp=0, digit_idx=3. Any display in progress is abandoned.
//   CONVERT: exactly 8 cycles (one per input bit, MSB first; add 3 to any BCD nibble >=5 before shift).
//     busy high for exactly those 8 cycles. load here: value captured into pending reg (latest wins),
//     current conversion continues; on completion its result is discarded and a fresh 8-cycle
//     CONVERT of the pending value starts immediately (busy stays high, 16 cycles total).
//   Digit list after conversion: H,T,O if H!=0; T,O if H==0 and T!=0; O only otherwise
//     (value 0 shows "0").
//   Cycle after busy falls: SHOW with first listed digit; seg = encoding, digit_idx set.
//   SHOW lasts DWELL cycles -> GAP (seg=0, dp=0, digit_idx=3) for GAP cycles -> next digit.
//     After ones digit's SHOW: FRAME_GAP for 2*GAP cycles (blank), then restart at first digit.
//     Frame repeats indefinitely until load or reset.
//   dp=1 exactly during SHOW of the ones digit.
//   Encoding: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; any other nibble -> 00 (unreachable).
//   Counter reloads at each state entry; no wrap beyond terminal count; load during SHOW/GAP
//     takes effect regardless of counter position.
// TESTING (bench uses DWELL=4, GAP=2)
//   1. reset, no load for 50 cycles -> seg=00, dp=0, digit_idx=3, busy=0 throughout.
//   2. load value=123 -> busy high 8 cycles; then seg=06 x4, 00 x2, 5B x4, 00 x2, 4F+dp=1 x4,
//      00 x4, then 06 again (frame period 20 cycles).
//   3. load 7 -> after busy, seg=07 dp=1 x4, 00 x4, repeat; load 0 -> 3F dp=1; load 40 -> 66, 3F+dp.
//   4. load 255, then load 40 on 3rd CONVERT cycle -> busy high 16 contiguous cycles; first shown
//      digit is 66 (4), never 5B (2).
//   5. load 123, load 9 during tens SHOW -> next cycle busy=1, seg=00; after 8 cycles seg=6F dp=1.
//   6. reset asserted together with load during SHOW -> next cycle all outputs at reset values, IDLE,
//      no conversion starts.

Source files
------------

// File: rtl/seg_display_sequencer.sv
// Shows an 8-bit binary result on one 7-segment display: serial double-dabble conversion,
// then hundreds/tens/ones one digit at a time with blanks between them, leading zeros dropped.
module seg_display_sequencer #(
  parameter int unsigned DWELL = 10_000_000,
  parameter int unsigned GAP   = 2_000_000,
  parameter int unsigned CNT_W = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       load,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] digit_idx,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StConvert, StShow, StGap, StFrameGap} state_e;

  localparam logic [CNT_W-1:0] DwellLd = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GapLd   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] FrameLd = CNT_W'(2 * GAP - 1);

  state_e           state_q;
  logic [7:0]       shift_q, pend_val_q;
  logic [11:0]      bcd_q, bcd_adj, bcd_step;
  logic [2:0]       bit_cnt_q;
  logic             pend_q;
  logic [1:0]       digit_q, nxt_digit, first_step, first_cur;
  logic [CNT_W-1:0] cnt_q;
  logic [6:0]       seg_q;
  logic             dp_q, busy_q;
  logic [1:0]       idx_q;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    unique case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] nibble(input logic [11:0] b, input logic [1:0] i);
    return b[4*i +: 4];
  endfunction

  // Index of the most significant non-zero digit; ones is always shown.
  function automatic logic [1:0] first_digit(input logic [11:0] b);
    if (b[11:8] != 4'd0) return 2'd2;
    if (b[7:4] != 4'd0) return 2'd1;
    return 2'd0;
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
    bcd_step   = {bcd_adj[10:0], shift_q[7]};
    first_step = first_digit(bcd_step);
    first_cur  = first_digit(bcd_q);
    nxt_digit  = digit_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      pend_val_q <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      pend_q     <= 1'b0;
      digit_q    <= '0;
      cnt_q      <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      idx_q      <= 2'd3;
      busy_q     <= 1'b0;
    end else if (load && state_q != StConvert) begin
      state_q   <= StConvert;
      shift_q   <= value;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b1;
      seg_q     <= '0;
      dp_q      <= 1'b0;
      idx_q     <= 2'd3;
    end else begin
      unique case (state_q)
        StIdle: ;
        StConvert: begin
          shift_q   <= {shift_q[6:0], 1'b0};
          bcd_q     <= bcd_step;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (load) begin
            pend_q     <= 1'b1;
            pend_val_q <= value;
          end
          if (bit_cnt_q == 3'd7) begin
            if (pend_q || load) begin
              // A newer value arrived mid-conversion: drop this result and convert again.
              shift_q   <= load ? value : pend_val_q;
              bcd_q     <= '0;
              bit_cnt_q <= '0;
              pend_q    <= 1'b0;
            end else begin
              state_q <= StShow;
              busy_q  <= 1'b0;
              digit_q <= first_step;
              seg_q   <= seg_enc(nibble(bcd_step, first_step));
              dp_q    <= (first_step == 2'd0);
              idx_q   <= first_step;
              cnt_q   <= DwellLd;
            end
          end
        end
        StShow: begin
          if (cnt_q == '0) begin
            state_q <= (digit_q == 2'd0) ? StFrameGap : StGap;
            cnt_q   <= (digit_q == 2'd0) ? FrameLd : GapLd;
            seg_q   <= '0;
            dp_q    <= 1'b0;
            idx_q   <= 2'd3;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            state_q <= StShow;
            digit_q <= nxt_digit;
            seg_q   <= seg_enc(nibble(bcd_q, nxt_digit));
            dp_q    <= (nxt_digit == 2'd0);
            idx_q   <= nxt_digit;
            cnt_q   <= DwellLd;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFrameGap: begin
          if (cnt_q == '0) begin
            state_q <= StShow;
            digit_q <= first_cur;
            seg_q   <= seg_enc(nibble(bcd_q, first_cur));
            dp_q    <= (first_cur == 2'd0);
            idx_q   <= first_cur;
            cnt_q   <= DwellLd;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seg_display_sequencer.sv
// Scoreboarded bench: the driver queues per-cycle expected outputs, the monitor checks each cycle.
module tb_seg_display_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value = '0;
  logic       load = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_idx;
  logic       busy;

  seg_display_sequencer #(
    .DWELL(4),
    .GAP  (2),
    .CNT_W(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .seg      (seg),
    .dp       (dp),
    .digit_idx(digit_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         test;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   ecyc = 0;
  int   test_no = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || seg !== e.seg || dp !== e.dp || digit_idx !== e.idx
          || busy !== e.busy) begin
        errors++;
        $display("FAIL test%0d cyc=%0d (exp cyc %0d) got seg=%h dp=%b idx=%0d busy=%b want seg=%h dp=%b idx=%0d busy=%b",
                 e.test, cyc, e.cyc, seg, dp, digit_idx, busy, e.seg, e.dp, e.idx, e.busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expn(input int n, input logic [6:0] s, input logic d, input logic [1:0] i,
                      input logic b);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.cyc  = ecyc;
      e.test = test_no;
      e.seg  = s;
      e.dp   = d;
      e.idx  = i;
      e.busy = b;
      q.push_back(e);
      ecyc++;
    end
  endtask

  task automatic blank(input int n);
    expn(n, 7'h00, 1'b0, 2'd3, 1'b0);
  endtask

  task automatic busyn(input int n);
    expn(n, 7'h00, 1'b0, 2'd3, 1'b1);
  endtask

  task automatic load_at(input int c, input logic [7:0] v);
    go_to(c);
    load  = 1'b1;
    value = v;
    tick();
    load  = 1'b0;
  endtask

  // Load so that its first effect lands right after the last queued expectation.
  task automatic issue_load(input logic [7:0] v);
    load_at(ecyc - 1, v);
  endtask

  int start;

  initial begin
    // 1: reset held, then 50 idle cycles
    test_no = 1;
    tick();
    ecyc = cyc;
    blank(53);
    go_to(3);
    reset = 1'b0;

    // 2: 123 -> H,T,O frame repeating every 20 cycles
    test_no = 2;
    issue_load(8'd123);
    busyn(8);
    for (int f = 0; f < 2; f++) begin
      expn(4, 7'h06, 1'b0, 2'd2, 1'b0);
      blank(2);
      expn(4, 7'h5B, 1'b0, 2'd1, 1'b0);
      blank(2);
      expn(4, 7'h4F, 1'b1, 2'd0, 1'b0);
      blank(4);
    end
    expn(4, 7'h06, 1'b0, 2'd2, 1'b0);

    // 3: leading-zero suppression
    test_no = 3;
    issue_load(8'd7);
    busyn(8);
    expn(4, 7'h07, 1'b1, 2'd0, 1'b0);
    blank(4);
    expn(4, 7'h07, 1'b1, 2'd0, 1'b0);
    issue_load(8'd0);
    busyn(8);
    expn(4, 7'h3F, 1'b1, 2'd0, 1'b0);
    blank(4);
    expn(4, 7'h3F, 1'b1, 2'd0, 1'b0);
    issue_load(8'd40);
    busyn(8);
    expn(4, 7'h66, 1'b0, 2'd1, 1'b0);
    blank(2);
    expn(4, 7'h3F, 1'b1, 2'd0, 1'b0);
    blank(4);
    expn(4, 7'h66, 1'b0, 2'd1, 1'b0);

    // 4: load during CONVERT re-runs conversion on the newer value
    test_no = 4;
    issue_load(8'd255);
    start = ecyc;
    busyn(16);
    expn(4, 7'h66, 1'b0, 2'd1, 1'b0);
    blank(2);
    expn(4, 7'h3F, 1'b1, 2'd0, 1'b0);
    blank(4);
    load_at(start + 2, 8'd40);

    // 5: load during tens SHOW abandons the display
    test_no = 5;
    issue_load(8'd123);
    start = ecyc;
    busyn(8);
    expn(4, 7'h06, 1'b0, 2'd2, 1'b0);
    blank(2);
    expn(2, 7'h5B, 1'b0, 2'd1, 1'b0);
    load_at(start + 15, 8'd9);
    busyn(8);
    expn(4, 7'h6F, 1'b1, 2'd0, 1'b0);
    blank(4);
    expn(4, 7'h6F, 1'b1, 2'd0, 1'b0);

    // 6: reset beats a simultaneous load
    test_no = 6;
    issue_load(8'd123);
    start = ecyc;
    busyn(8);
    expn(2, 7'h06, 1'b0, 2'd2, 1'b0);
    go_to(start + 9);
    reset = 1'b1;
    load  = 1'b1;
    value = 8'd55;
    tick();
    reset = 1'b0;
    load  = 1'b0;
    blank(20);

    go_to(ecyc);
    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d unchecked entries want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
